mem_bus_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the shared 8-bit memory/I-O bus. It sits between the CPU and the DMA/loader engine on one side and the single-port memory block (sync ROM 0x00–0x7F, sync RAM 0x80–0xDF, I/O ports 0xF0–0xFF) on the other. Each cycle it chooses one requester and drives the memory address, write and data lines. It holds the address through the read-data cycle, so synchronous ROM/RAM and combinational port reads both return correct data. It also blocks writes to the ROM range.

---
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of CPU/DMA requester handshakes and the shared memory-bus lines.
// The arbiter takes the slave view; the system and memory side take the master view.
interface mem_bus_arbiter_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt;
    logic       cpu_rvalid;
    logic [7:0] cpu_rdata;

    logic       dma_req;
    logic       dma_we;
    logic [7:0] dma_addr;
    logic [7:0] dma_wdata;
    logic       dma_lock;
    logic       dma_gnt;
    logic       dma_rvalid;
    logic [7:0] dma_rdata;

    logic       prot_err;

    logic [7:0] mem_address;
    logic       mem_write;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output prot_err,
        output mem_address, mem_write, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  prot_err,
        input  mem_address, mem_write, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter and access sequencer for the shared 8-bit memory/I-O bus.
// Define ARB_ROUND_ROBIN_EN for alternating conflict resolution; default is fixed CPU priority.
module mem_bus_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int         HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic       CPU      = 1'b0;
    localparam logic       DMA      = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        RDATA = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [7:0]        rd_addr_reg;
    logic [1:0]        rvalid_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              last_owner_reg;
    logic              prot_err_reg;

    // Requester-indexed views: index 0 is the CPU, index 1 the DMA engine.
    logic [1:0]        req;
    logic [1:0]        we_vec;
    logic [1:0][7:0]   addr_vec;
    logic [1:0][7:0]   wdata_vec;
    logic [1:0][7:0]   rdata_vec;
    logic [1:0]        gnt;

    logic              win;
    logic              any_gnt;
    logic              win_we;
    logic [7:0]        win_addr;
    logic [7:0]        win_wdata;
    logic              win_rom;
    logic              start_read;
    logic              hold_full;
    logic              policy_dma;

    logic [7:0]        mem_address;
    logic              mem_write;
    logic [7:0]        mem_data_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            if (gi == 0) begin : g_cpu
                assign req[gi]        = bus.cpu_req;
                assign we_vec[gi]     = bus.cpu_we;
                assign addr_vec[gi]   = bus.cpu_addr;
                assign wdata_vec[gi]  = bus.cpu_wdata;
                assign bus.cpu_gnt    = gnt[gi];
                assign bus.cpu_rvalid = rvalid_reg[gi];
                assign bus.cpu_rdata  = rdata_vec[gi];
            end else begin : g_dma
                assign req[gi]        = bus.dma_req;
                assign we_vec[gi]     = bus.dma_we;
                assign addr_vec[gi]   = bus.dma_addr;
                assign wdata_vec[gi]  = bus.dma_wdata;
                assign bus.dma_gnt    = gnt[gi];
                assign bus.dma_rvalid = rvalid_reg[gi];
                assign bus.dma_rdata  = rdata_vec[gi];
            end
            // Read data is forced to zero outside the owner's valid cycle.
            assign rdata_vec[gi] = rvalid_reg[gi] ? bus.mem_data_out : 8'h00;
        end
    endgenerate

`ifdef ARB_ROUND_ROBIN_EN
    assign policy_dma = (last_owner_reg == CPU);
`else
    assign policy_dma = 1'b0;
`endif

    assign hold_full = (hold_cnt_reg == HOLD_W'(MAX_HOLD));

    // Winner selection; grants only exist in the address phase.
    always_comb begin
        gnt = 2'b00;
        if (state_reg == IDLE) begin
            if (req == 2'b11) begin
                if (bus.dma_lock && (last_owner_reg == DMA)) begin
                    gnt = hold_full ? 2'b01 : 2'b10;
                end else begin
                    gnt = policy_dma ? 2'b10 : 2'b01;
                end
            end else begin
                gnt = req;
            end
        end
    end

    assign any_gnt    = |gnt;
    assign win        = gnt[DMA];
    assign win_we     = we_vec[win];
    assign win_addr   = addr_vec[win];
    assign win_wdata  = wdata_vec[win];
    assign win_rom    = ~win_addr[7];
    assign start_read = any_gnt && !win_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_read) state_next = RDATA;
            RDATA:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_address = 8'h00;
        mem_write   = 1'b0;
        mem_data_in = 8'h00;
        case (state_reg)
            IDLE: begin
                if (any_gnt) begin
                    mem_address = win_addr;
                    mem_write   = win_we && !win_rom;
                    mem_data_in = win_wdata;
                end
            end
            RDATA: begin
                // Address held so synchronous ROM/RAM and combinational ports both return data.
                mem_address = rd_addr_reg;
            end
            default: begin
                mem_address = 8'h00;
            end
        endcase
    end

    assign bus.mem_address = mem_address;
    assign bus.mem_write   = mem_write;
    assign bus.mem_data_in = mem_data_in;
    assign bus.prot_err    = prot_err_reg;

    // The DMA hold counter only measures how long a waiting CPU has been held off.
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (!bus.cpu_req || gnt[CPU]) begin
            hold_cnt_next = '0;
        end else if (gnt[DMA] && !hold_full) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_reg    <= 8'h00;
            rvalid_reg     <= 2'b00;
            hold_cnt_reg   <= '0;
            last_owner_reg <= CPU;
            prot_err_reg   <= 1'b0;
        end else begin
            prot_err_reg <= any_gnt && win_we && win_rom;
            rvalid_reg   <= start_read ? gnt : 2'b00;
            hold_cnt_reg <= hold_cnt_next;
            if (any_gnt) begin
                last_owner_reg <= win;
            end
            if (start_read) begin
                rd_addr_reg <= win_addr;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;
    localparam int MAX_HOLD = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_bus_arbiter_if bus ();
    mem_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Requester drive (index 0 = CPU, 1 = DMA)
    logic [1:0] t_req   = 2'b00;
    logic [1:0] t_we    = 2'b00;
    logic       t_lock  = 1'b0;
    logic [7:0] t_addr  [2];
    logic [7:0] t_wdata [2];

    assign bus.cpu_req   = t_req[0];
    assign bus.cpu_we    = t_we[0];
    assign bus.cpu_addr  = t_addr[0];
    assign bus.cpu_wdata = t_wdata[0];
    assign bus.dma_req   = t_req[1];
    assign bus.dma_we    = t_we[1];
    assign bus.dma_addr  = t_addr[1];
    assign bus.dma_wdata = t_wdata[1];
    assign bus.dma_lock  = t_lock;

    function automatic logic [7:0] init_val(input int a);
        if (a == 5) return 8'hA5;
        return 8'(a * 37 + 11);
    endfunction

    // Memory block: sync ROM/RAM below 0xF0, combinational I/O ports above.
    logic [7:0] mem [256];
    logic [7:0] sync_q;
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            sync_q    <= 8'h00;
            mem_ready <= 1'b1;
        end else begin
            sync_q <= mem[bus.mem_address];
            if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_in;
        end
    end
    assign bus.mem_data_out = (bus.mem_address >= 8'hF0) ? mem[bus.mem_address] : sync_q;

    // Behavioural model state
    logic [7:0] shadow [256];
    logic       m_busy;
    logic       m_rd_owner;
    logic [7:0] m_rd_addr;
    logic       m_last;
    int         m_streak;
    logic       m_prot;
    logic       m_any;
    logic       m_ws;

    task automatic model_reset();
        m_busy     = 1'b0;
        m_rd_owner = 1'b0;
        m_rd_addr  = 8'h00;
        m_last     = 1'b0;
        m_streak   = 0;
        m_prot     = 1'b0;
        m_any      = 1'b0;
        m_ws       = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        logic       any, ws, e_wr, e_cv, e_dv;
        logic [7:0] e_addr, e_din, e_crd, e_drd;
        if (reset) begin
            model_reset();
            return;
        end
        any = 1'b0;
        ws  = 1'b0;
        if (!m_busy && t_req != 2'b00) begin
            any = 1'b1;
            if (t_req == 2'b11) begin
                if (t_lock && m_last) ws = (m_streak < MAX_HOLD);
                else                  ws = ROUND_ROBIN ? !m_last : 1'b0;
            end else begin
                ws = t_req[1];
            end
        end
        e_addr = any ? t_addr[ws] : (m_busy ? m_rd_addr : 8'h00);
        e_wr   = any && t_we[ws] && (t_addr[ws] >= 8'h80);
        e_din  = any ? t_wdata[ws] : 8'h00;
        e_cv   = m_busy && !m_rd_owner;
        e_dv   = m_busy && m_rd_owner;
        e_crd  = e_cv ? shadow[m_rd_addr] : 8'h00;
        e_drd  = e_dv ? shadow[m_rd_addr] : 8'h00;

        chk("cpu_gnt",     8'(bus.cpu_gnt),    8'(any && !ws));
        chk("dma_gnt",     8'(bus.dma_gnt),    8'(any && ws));
        chk("mem_address", bus.mem_address,    e_addr);
        chk("mem_write",   8'(bus.mem_write),  8'(e_wr));
        chk("mem_data_in", bus.mem_data_in,    e_din);
        chk("cpu_rvalid",  8'(bus.cpu_rvalid), 8'(e_cv));
        chk("dma_rvalid",  8'(bus.dma_rvalid), 8'(e_dv));
        chk("cpu_rdata",   bus.cpu_rdata,      e_crd);
        chk("dma_rdata",   bus.dma_rdata,      e_drd);
        chk("prot_err",    8'(bus.prot_err),   8'(m_prot));

        m_prot = any && t_we[ws] && (t_addr[ws] < 8'h80);
        if (e_wr) shadow[t_addr[ws]] = t_wdata[ws];
        m_busy = any && !t_we[ws];
        if (m_busy) begin
            m_rd_owner = ws;
            m_rd_addr  = t_addr[ws];
        end
        if (!t_req[0] || (any && !ws))              m_streak = 0;
        else if (any && ws && m_streak < MAX_HOLD) m_streak++;
        if (any) m_last = ws;
        m_any = any;
        m_ws  = ws;
    endtask

    task automatic sample();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [7:0] a, input logic [7:0] d);
        t_req[r]   = 1'b1;
        t_we[r]    = we;
        t_addr[r]  = a;
        t_wdata[r] = d;
    endtask

    initial begin : main
        int         cpu_cnt, dma_cnt;
        logic [3:0] seq;
        t_addr[0] = 8'h00; t_addr[1] = 8'h00;
        t_wdata[0] = 8'h00; t_wdata[1] = 8'h00;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        model_reset();

        // Reset values
        #2;
        chk("rst_cpu_gnt",  8'(bus.cpu_gnt),    8'h00);
        chk("rst_dma_gnt",  8'(bus.dma_gnt),    8'h00);
        chk("rst_rvalid",   8'({bus.cpu_rvalid, bus.dma_rvalid}), 8'h00);
        chk("rst_prot_err", 8'(bus.prot_err),   8'h00);
        chk("rst_mem_addr", bus.mem_address,    8'h00);
        chk("rst_mem_wr",   8'(bus.mem_write),  8'h00);
        chk("rst_mem_din",  bus.mem_data_in,    8'h00);
        chk("rst_rdata",    bus.cpu_rdata | bus.dma_rdata, 8'h00);
        #10;
        advance();
        reset = 1'b0;

        // CPU reads ROM 0x05
        set_req(0, 1'b0, 8'h05, 8'h00);
        sample();
        chk("t1_cpu_gnt", 8'(bus.cpu_gnt), 8'h01);
        advance();
        t_req[0] = 1'b0;
        sample();
        chk("t1_rvalid", 8'(bus.cpu_rvalid), 8'h01);
        chk("t1_rdata",  bus.cpu_rdata,      8'hA5);
        chk("t1_addr",   bus.mem_address,    8'h05);
        $display("txn cpu read 05 -> %02h", bus.cpu_rdata);
        advance();

        // DMA writes RAM 0x90, CPU reads it back
        set_req(1, 1'b1, 8'h90, 8'h3C);
        sample();
        chk("t2_mem_write", 8'(bus.mem_write), 8'h01);
        $display("txn dma write 90 <- 3c");
        advance();
        t_req[1] = 1'b0;
        set_req(0, 1'b0, 8'h90, 8'h00);
        sample();
        chk("t2_wr_once", 8'(bus.mem_write), 8'h00);
        advance();
        t_req[0] = 1'b0;
        sample();
        chk("t2_rdata", bus.cpu_rdata, 8'h3C);
        $display("txn cpu read 90 -> %02h", bus.cpu_rdata);
        advance();

        // DMA write into ROM is dropped
        set_req(1, 1'b1, 8'h10, 8'h77);
        sample();
        chk("t3_dma_gnt",   8'(bus.dma_gnt),   8'h01);
        chk("t3_mem_write", 8'(bus.mem_write), 8'h00);
        $display("txn dma write 10 <- 77 (rom)");
        advance();
        t_req[1] = 1'b0;
        set_req(0, 1'b0, 8'h10, 8'h00);
        sample();
        chk("t3_prot_err", 8'(bus.prot_err), 8'h01);
        advance();
        t_req[0] = 1'b0;
        sample();
        chk("t3_rom_kept", bus.cpu_rdata, 8'h5B);
        $display("txn cpu read 10 -> %02h", bus.cpu_rdata);
        advance();

        // Both read continuously, unlocked
        set_req(0, 1'b0, 8'h30, 8'h00);
        set_req(1, 1'b0, 8'h40, 8'h00);
        cpu_cnt = 0;
        dma_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            sample();
            cpu_cnt += int'(bus.cpu_gnt);
            dma_cnt += int'(bus.dma_gnt);
            advance();
        end
        chk("t4_cpu_grants", 8'(cpu_cnt), ROUND_ROBIN ? 8'd2 : 8'd4);
        chk("t4_dma_grants", 8'(dma_cnt), ROUND_ROBIN ? 8'd2 : 8'd0);
        $display("txn contention reads cpu=%0d dma=%0d", cpu_cnt, dma_cnt);
        t_req = 2'b00;
        sample();
        advance();

        // Locked DMA burst against a waiting CPU
        t_lock = 1'b1;
        set_req(1, 1'b1, 8'h95, 8'h11);
        sample();
        advance();
        set_req(0, 1'b0, 8'h20, 8'h00);
        set_req(1, 1'b1, 8'hA0, 8'h20);
        seq = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            sample();
            seq = {seq[2:0], bus.cpu_gnt};
            advance();
            if (m_any && m_ws)  set_req(1, 1'b1, t_addr[1] + 8'h01, t_wdata[1] + 8'h01);
            if (m_any && !m_ws) t_req[0] = 1'b0;
        end
        chk("t5_grant_seq", 8'(seq), 8'h01);
        sample();
        advance();
        sample();
        chk("t5_dma_resume", 8'(bus.dma_gnt), 8'h01);
        $display("txn locked burst seq=%04b", seq);
        advance();
        t_req  = 2'b00;
        t_lock = 1'b0;
        sample();
        advance();

        // Reset during the read-data phase of a DMA read
        set_req(1, 1'b0, 8'hC0, 8'h00);
        sample();
        advance();
        t_req[1] = 1'b0;
        reset    = 1'b1;
        #1;
        chk("t6_dma_rvalid", 8'(bus.dma_rvalid), 8'h00);
        chk("t6_dma_rdata",  bus.dma_rdata,      8'h00);
        chk("t6_mem_addr",   bus.mem_address,    8'h00);
        $display("txn reset during dma read");
        sample();
        advance();
        reset = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 32 == 0) t_lock = 1'($urandom_range(0, 1));
            for (int r = 0; r < 2; r++) begin
                if (!t_req[r] || (m_any && m_ws == r[0])) begin
                    t_req[r]   = ($urandom_range(0, 3) != 0);
                    t_we[r]    = 1'($urandom_range(0, 1));
                    t_addr[r]  = 8'($urandom);
                    t_wdata[r] = 8'($urandom);
                end
            end
            sample();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
